alu_shift_pipe: RTL and testbench
=================================

// Module: alu_shift_pipe
//
// PURPOSE
//   Pipelined, parametrised barrel shifter for the ALU. Supports logical and arithmetic shifts and rotates.
//   Operands enter through a valid/ready handshake, travel through a configurable number of register
//   stages and leave through a valid/ready handshake. Used on long-path datapaths where the
//   single-cycle shifter does not meet timing.
//
// PARAMETERS
//   WIDTH   32  operand/result width; power of two, 8..64
//   SHW     5   shift-amount width; must equal log2(WIDTH)
//   STAGES  2   pipeline register stages, 1..SHW; shift levels split across stages, earliest stages take the larger share
//   TAG_W   4   sideband tag width; carried unchanged alongside each operation
//
// PORTS
//   clk        in   1       clock, all state on rising edge
//   reset      in   1       asynchronous, active-high reset
//   in_valid   in   1       operation present on a/b/sfn/in_tag
//   in_ready   out  1       block accepts operation this cycle
//   a          in   WIDTH   operand to shift
//   b          in   SHW     shift amount, 0..WIDTH-1
//   sfn        in   3       [0]=right, [1]=arithmetic (right only), [2]=rotate
//   in_tag     in   TAG_W   sideband tag
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts result
//   y          out  WIDTH   shifted result
//   out_tag    out  TAG_W   tag of the operation in y
//   zero       out  1       y == 0, aligned with y
//
// BEHAVIOUR
//   Function by sfn:
//     000 SHL (zero fill)
//     001 SHR (zero fill)
//     011 SRA (fill a[WIDTH-1])
//     010 SHL; arithmetic bit ignored for left shifts
//     1x0 ROL; 1x1 ROR; arithmetic bit ignored when rotating
//   Implementation: right ops bit-reverse in, shift left, bit-reverse out.
//     Shift level k (shift by 2^k) in stage floor(k*STAGES/SHW), counting from MSB level down.
//   Handshake:
//     - transfer on in_valid&&in_ready, and separately on out_valid&&out_ready
//     - stall = out_valid && !out_ready; whole pipeline freezes
//     - in_ready = !stall; combinational, no dependency on in_valid
//   Latency: exactly STAGES cycles from accept to out_valid when no stall; one op per cycle sustained.
//   Pipeline:
//     - each stage holds valid bit, partial result, fill bit, shift-amount remainder, sfn, tag
//     - a bubble (in_valid=0) propagates as valid=0; never drops or duplicates ops
//     - when stalled, y/out_tag/zero and all stage contents hold stable
//   Reset (async, any time including mid-operation):
//     - all valid bits 0; out_valid=0, y=0, out_tag=0, zero=1
//     - in-flight ops discarded
//     - in_ready=1 while reset is high and on the first cycle after release
//   Boundaries:
//     - b=0 passes a unchanged for every mode
//     - b=WIDTH-1 with SRA yields all copies of the sign bit
//     - out_ready=1 with out_valid=0 has no effect
//     - accept and retire in the same cycle at full occupancy is legal; no bubble is inserted
//
// TESTING  (WIDTH=32, STAGES=2)
//   1. SRA a=0x80000000 b=31 -> y=0xFFFFFFFF 2 cycles later; SHR same a/b -> 0x00000001; SHL a=1 b=31 -> 0x80000000
//   2. ROR a=0x00000001 b=1 -> 0x80000000; ROL a=0x80000001 b=4 -> 0x00000018; sfn=111 equals ROR
//   3. Every mode with b=0, a=0xDEADBEEF -> y=0xDEADBEEF; SHL a=0x1 b=0 check zero=0; SHR a=1 b=1 -> y=0, zero=1
//   4. 8 back-to-back ops, tags 0..7 -> results in order, tags 0..7, one per cycle after 2-cycle fill
//   5. Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, y/out_tag stable, no op lost or duplicated
//   6. Assert reset with 2 ops in flight -> out_valid=0 immediately, y=0; next op after release appears with latency 2
//   7. Random ops vs reference model, STAGES=1..5 and WIDTH=8/64 -> bit-exact match, tag order preserved

Source files
------------

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter supporting SHL/SHR/SRA/ROL/ROR with a valid/ready handshake on each side.
// Right shifts bit-reverse the operand, shift left through the pipe, and reverse again at the output.
module alu_shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int SHW    = 5,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [2:0]       sfn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic              sign_q [STAGES];
    logic              sign_d [STAGES];
    logic [SHW-1:0]    amt_q  [STAGES];
    logic [SHW-1:0]    amt_d  [STAGES];
    logic [2:0]        sfn_q  [STAGES];
    logic [2:0]        sfn_d  [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];

    logic [STAGES-1:0] st_valid;
    logic [WIDTH-1:0]  st_data [STAGES];
    logic              st_sign [STAGES];
    logic [SHW-1:0]    st_amt  [STAGES];
    logic [2:0]        st_sfn  [STAGES];
    logic [TAG_W-1:0]  st_tag  [STAGES];

    logic              stall;
    logic [WIDTH-1:0]  lvl_x;
    logic              lvl_fill;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    // Level index 0 is the largest shift (2^(SHW-1)); earlier stages take the larger share.
    function automatic int stage_of(input int lvl_idx);
        return (lvl_idx * STAGES) / SHW;
    endfunction

    function automatic logic [SHW-1:0] level_mask(input int s);
        logic [SHW-1:0] m;
        m = '0;
        for (int j = 0; j < SHW; j++) begin
            if (stage_of(j) == s) m[SHW-1-j] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                     input int sh,
                                                     input logic fill,
                                                     input logic rot);
        logic [WIDTH-1:0] r;
        r = x << sh;
        if (rot)
            r = r | (x >> (WIDTH - sh));
        else if (fill)
            r = r | ~({WIDTH{1'b1}} << sh);
        return r;
    endfunction

    always_comb begin : stage_inputs
        stall    = valid_q[LAST] && !out_ready;
        in_ready = !stall;

        st_valid    = '0;
        st_valid[0] = in_valid;
        st_data[0]  = sfn[0] ? bit_rev(a) : a;
        st_sign[0]  = a[WIDTH-1];
        st_amt[0]   = b;
        st_sfn[0]   = sfn;
        st_tag[0]   = in_tag;
        for (int s = 1; s < STAGES; s++) begin
            st_valid[s] = valid_q[s-1];
            st_data[s]  = data_q[s-1];
            st_sign[s]  = sign_q[s-1];
            st_amt[s]   = amt_q[s-1];
            st_sfn[s]   = sfn_q[s-1];
            st_tag[s]   = tag_q[s-1];
        end
    end

    always_comb begin : shift_levels
        valid_d  = '0;
        lvl_x    = '0;
        lvl_fill = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            // Sign fill only for SRA; the sign bit travels with the op and the mode gates it.
            lvl_fill = st_sign[s] && (st_sfn[s] == 3'b011);
            lvl_x    = st_data[s];
            for (int j = 0; j < SHW; j++) begin
                if (stage_of(j) == s && st_amt[s][SHW-1-j])
                    lvl_x = shift_level(lvl_x, 1 << (SHW-1-j), lvl_fill, st_sfn[s][2]);
            end
            valid_d[s] = st_valid[s];
            data_d[s]  = lvl_x;
            sign_d[s]  = st_sign[s];
            amt_d[s]   = st_amt[s] & ~level_mask(s);
            sfn_d[s]   = st_sfn[s];
            tag_d[s]   = st_tag[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                sign_q[s] <= 1'b0;
                amt_q[s]  <= '0;
                sfn_q[s]  <= '0;
                tag_q[s]  <= '0;
            end
        end else if (!stall) begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
                sign_q[s] <= sign_d[s];
                amt_q[s]  <= amt_d[s];
                sfn_q[s]  <= sfn_d[s];
                tag_q[s]  <= tag_d[s];
            end
        end
    end

    always_comb begin : outputs
        out_valid = valid_q[LAST];
        y         = sfn_q[LAST][0] ? bit_rev(data_q[LAST]) : data_q[LAST];
        out_tag   = tag_q[LAST];
        zero      = (data_q[LAST] == '0);
    end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe: a 32-bit/2-stage main instance with directed, stall and reset
// scenarios, plus 8/64-bit instances at other depths sharing the random stream.
module tb_alu_shift_pipe;

    localparam int W  = 32;
    localparam int SH = 5;
    localparam int ST = 2;
    localparam int TW = 4;
    localparam int NX = 4;

    typedef struct {
        logic [63:0] y;
        logic [3:0]  tag;
        int          cyc;
        int          stl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          drv_valid;
    logic [63:0]   drv_a;
    logic [5:0]    drv_b;
    logic [2:0]    drv_sfn;
    logic [3:0]    drv_tag;
    logic          drv_use_exp;
    logic [63:0]   drv_exp;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  y;
    logic [TW-1:0] out_tag;
    logic          zero;

    int   cyc = 0;
    int   stall_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   hold_cycles = 0;
    logic rand_en = 1'b0;
    logic final_chk = 1'b0;
    exp_t sb[$];
    exp_t h;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_shift_pipe #(.WIDTH(W), .SHW(SH), .STAGES(ST), .TAG_W(TW)) dut (
        .clk(clk), .reset(rst), .in_valid(drv_valid), .in_ready(in_ready),
        .a(drv_a[W-1:0]), .b(drv_b[SH-1:0]), .sfn(drv_sfn), .in_tag(drv_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag), .zero(zero)
    );

    // Reference: plain arithmetic on a w-bit value held in 64 bits.
    function automatic logic [63:0] ref_model(input logic [63:0] a, input int b,
                                              input logic [2:0] sfn, input int w);
        logic [63:0] m, v, r;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        v = a & m;
        if (sfn[2])
            r = sfn[0] ? ((v >> b) | (v << (w - b))) : ((v << b) | (v >> (w - b)));
        else if (!sfn[0])
            r = v << b;
        else if (sfn[1] && v[w-1])
            r = (v >> b) | (m & ~(m >> b));
        else
            r = v >> b;
        return r & m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_cycles > 0) begin
            out_ready = 1'b0;
            hold_cycles--;
        end else if (rand_en)
            out_ready = ($urandom_range(0, 3) != 0);
        else
            out_ready = 1'b1;
    endtask

    task automatic send(input logic [63:0] a, input logic [5:0] b, input logic [2:0] sfn,
                        input logic [3:0] tag, input logic use_exp, input logic [63:0] exp);
        drv_valid   = 1'b1;
        drv_a       = a;
        drv_b       = b;
        drv_sfn     = sfn;
        drv_tag     = tag;
        drv_use_exp = use_exp;
        drv_exp     = exp;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("accept timeout", 1, 0);
        drv_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Main scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (out_valid) begin
                if (sb.size() == 0)
                    check("unexpected out_valid", {63'd0, out_valid}, 0);
                else begin
                    h = sb[0];
                    check("y", {32'd0, y}, h.y);
                    check("out_tag", {60'd0, out_tag}, {60'd0, h.tag});
                    check("zero", {63'd0, zero}, {63'd0, h.y == 64'd0});
                    if (out_ready) begin
                        check("latency", cyc, h.cyc + ST + (stall_cnt - h.stl));
                        void'(sb.pop_front());
                    end
                end
            end
            if (drv_valid && in_ready)
                sb.push_back('{drv_use_exp ? drv_exp
                                           : ref_model(drv_a, int'(drv_b[4:0]), drv_sfn, W),
                               drv_tag, cyc, stall_cnt});
            if (out_valid && !out_ready) stall_cnt++;
        end
    end

    for (genvar g = 0; g < NX; g++) begin : gx
        localparam int GW  = (g < 2) ? 8 : 64;
        localparam int GSH = $clog2(GW);
        localparam int GST = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 5;
        logic          iv, ir, ov, zz;
        logic [GW-1:0] yy;
        logic [3:0]    ot;
        exp_t          q[$];
        exp_t          gh;

        assign iv = drv_valid && in_ready;

        alu_shift_pipe #(.WIDTH(GW), .SHW(GSH), .STAGES(GST), .TAG_W(4)) u (
            .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
            .a(drv_a[GW-1:0]), .b(drv_b[GSH-1:0]), .sfn(drv_sfn), .in_tag(drv_tag),
            .out_valid(ov), .out_ready(1'b1), .y(yy), .out_tag(ot), .zero(zz)
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                check($sformatf("x%0d in_ready", g), {63'd0, ir}, 1);
                if (ov) begin
                    if (q.size() == 0)
                        check($sformatf("x%0d unexpected out_valid", g), {63'd0, ov}, 0);
                    else begin
                        gh = q.pop_front();
                        check($sformatf("x%0d y", g), 64'(yy), gh.y);
                        check($sformatf("x%0d out_tag", g), {60'd0, ot}, {60'd0, gh.tag});
                        check($sformatf("x%0d zero", g), {63'd0, zz}, {63'd0, gh.y == 64'd0});
                        check($sformatf("x%0d latency", g), cyc, gh.cyc + GST);
                    end
                end
                if (iv && ir)
                    q.push_back('{ref_model(drv_a, int'(drv_b) % GW, drv_sfn, GW), drv_tag, cyc, 0});
            end
        end

        always @(posedge final_chk) check($sformatf("x%0d drain", g), q.size(), 0);
    end

    initial begin
        rst         = 1'b1;
        drv_valid   = 1'b0;
        drv_a       = '0;
        drv_b       = '0;
        drv_sfn     = '0;
        drv_tag     = '0;
        drv_use_exp = 1'b0;
        drv_exp     = '0;
        out_ready   = 1'b1;
        #2;
        check("reset out_valid", {63'd0, out_valid}, 0);
        check("reset y", {32'd0, y}, 0);
        check("reset out_tag", {60'd0, out_tag}, 0);
        check("reset zero", {63'd0, zero}, 1);
        check("reset in_ready", {63'd0, in_ready}, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Extremes of shift amount and rotate direction.
        send(64'h80000000, 6'd31, 3'b011, 4'd1, 1'b1, 64'hFFFFFFFF);
        send(64'h80000000, 6'd31, 3'b001, 4'd2, 1'b1, 64'h00000001);
        send(64'h00000001, 6'd31, 3'b000, 4'd3, 1'b1, 64'h80000000);
        send(64'h00000001, 6'd1,  3'b101, 4'd4, 1'b1, 64'h80000000);
        send(64'h80000001, 6'd4,  3'b100, 4'd5, 1'b1, 64'h00000018);
        send(64'h00000001, 6'd1,  3'b111, 4'd6, 1'b1, 64'h80000000);
        send(64'h00000003, 6'd2,  3'b010, 4'd7, 1'b1, 64'h0000000C);
        for (int m = 0; m < 8; m++)
            send(64'hDEADBEEF, 6'd0, 3'(m), 4'(m), 1'b1, 64'hDEADBEEF);
        send(64'h00000001, 6'd0, 3'b000, 4'd8, 1'b1, 64'h00000001);
        send(64'h00000001, 6'd1, 3'b001, 4'd9, 1'b1, 64'h00000000);
        idle(4);

        // Back-to-back stream, tags 0..7.
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                 4'(i), 1'b0, 64'd0);
        idle(4);

        // Five-cycle output stall in the middle of a stream.
        for (int i = 0; i < 12; i++) begin
            if (i == 3) hold_cycles = 5;
            send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                 4'(i), 1'b0, 64'd0);
        end
        idle(6);

        // Reset with ops in flight.
        send(64'h00000010, 6'd1, 3'b000, 4'hA, 1'b0, 64'd0);
        send(64'h00000020, 6'd1, 3'b000, 4'hB, 1'b0, 64'd0);
        rst = 1'b1;
        #1;
        check("midreset out_valid", {63'd0, out_valid}, 0);
        check("midreset y", {32'd0, y}, 0);
        check("midreset out_tag", {60'd0, out_tag}, 0);
        check("midreset zero", {63'd0, zero}, 1);
        check("midreset in_ready", {63'd0, in_ready}, 1);
        idle(2);
        rst = 1'b0;
        #1;
        check("release in_ready", {63'd0, in_ready}, 1);
        send(64'h12345678, 6'd4, 3'b100, 4'hC, 1'b1, 64'h23456781);
        idle(4);

        // Randomised traffic with random backpressure and bubbles.
        rand_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [5:0] bb;
            case ($urandom_range(0, 5))
                0:       bb = 6'd0;
                1:       bb = 6'd31;
                2:       bb = 6'd63;
                default: bb = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 4) == 0) idle(1);
            send({$urandom, $urandom}, bb, 3'($urandom_range(0, 7)), 4'(i), 1'b0, 64'd0);
        end
        rand_en = 1'b0;
        idle(30);

        check("main drain", sb.size(), 0);
        final_chk = 1'b1;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
